// File: rtl/map_pkg.sv
// Shared cell codes and scan state encoding for the maze map scanner.
// Imported by map_scan_ctrl.
package map_pkg;

    localparam logic [6:0] CELL_START = 7'h3F;
    localparam logic [6:0] CELL_GOAL  = 7'h00;
    localparam int         WALL_BIT   = 6;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        FEED,
        DONE
    } scan_state_t;

endpackage

// File: rtl/map_scan_ctrl.sv
// Walks the map RAM cell by cell, feeds the search stage and latches start/goal.
// Optional wall counter enabled by defining MAP_SCAN_WALL_CNT_EN.
module map_scan_ctrl
    import map_pkg::*;
#(
    parameter int CELLS  = 100,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 7,
    parameter int RD_LAT = 1
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              scan_req,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] blk_map,
    output logic [ADDR_W-1:0] blk_now,
    output logic              blk_do,
    input  logic [ADDR_W-1:0] blk_start,
    input  logic [ADDR_W-1:0] blk_goal,
    output logic [ADDR_W-1:0] start_pos,
    output logic [ADDR_W-1:0] goal_pos,
    output logic              start_found,
    output logic              goal_found,
    output logic              err_dup,
    output logic              err_missing,
    output logic [ADDR_W-1:0] wall_cnt
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);
    localparam logic [WCW-1:0]    WLAST = WCW'(RD_LAT - 1);

    scan_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [WCW-1:0]    wcnt;

    logic is_start;
    logic is_goal;
    logic sf_nx;
    logic gf_nx;

    assign is_start = (blk_map == DATA_W'(CELL_START));
    assign is_goal  = (blk_map == DATA_W'(CELL_GOAL));
    // Include the last cell's markers so err_missing lands with scan_done
    assign sf_nx    = start_found | is_start;
    assign gf_nx    = goal_found | is_goal;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            blk_map     <= '0;
            blk_now     <= '0;
            blk_do      <= 1'b0;
            start_pos   <= '0;
            goal_pos    <= '0;
            start_found <= 1'b0;
            goal_found  <= 1'b0;
            err_dup     <= 1'b0;
            err_missing <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            blk_do    <= 1'b0;
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan_req) begin
                        state       <= RD;
                        idx         <= '0;
                        mem_addr    <= '0;
                        mem_rd      <= 1'b1;
                        scan_busy   <= 1'b1;
                        start_pos   <= '0;
                        goal_pos    <= '0;
                        start_found <= 1'b0;
                        goal_found  <= 1'b0;
                        err_dup     <= 1'b0;
                        err_missing <= 1'b0;
                    end
                end
                RD: begin
                    state <= WAIT;
                    wcnt  <= '0;
                end
                WAIT: begin
                    if (wcnt == WLAST) begin
                        state   <= FEED;
                        blk_map <= mem_rdata;
                        blk_now <= idx;
                        blk_do  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                FEED: begin
                    if (is_start) begin
                        if (!start_found) begin
                            start_pos   <= blk_start;
                            start_found <= 1'b1;
                        end else begin
                            err_dup <= 1'b1;
                        end
                    end
                    if (is_goal) begin
                        if (!goal_found) begin
                            goal_pos   <= blk_goal;
                            goal_found <= 1'b1;
                        end else begin
                            err_dup <= 1'b1;
                        end
                    end
                    if (idx == LAST) begin
                        state       <= DONE;
                        scan_done   <= 1'b1;
                        err_missing <= !(sf_nx & gf_nx);
                    end else begin
                        state    <= RD;
                        idx      <= idx + 1'b1;
                        mem_addr <= idx + 1'b1;
                        mem_rd   <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAP_SCAN_WALL_CNT_EN
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            wall_cnt <= '0;
        end else if (state == IDLE && scan_req) begin
            wall_cnt <= '0;
        end else if (state == FEED && blk_map[WALL_BIT]
                     && wall_cnt != '1) begin
            wall_cnt <= wall_cnt + 1'b1;
        end
    end
`else
    assign wall_cnt = '0;
`endif

endmodule

// File: tb/tb_map_scan_ctrl.sv
// Self-checking bench for map_scan_ctrl with a 4-cell map and 1-cycle RAM.
// Expected wall counts follow MAP_SCAN_WALL_CNT_EN.
module tb_map_scan_ctrl;

    logic       m_clock;
    logic       p_reset;
    logic       scan_req;
    logic       scan_busy;
    logic       scan_done;
    logic [6:0] mem_addr;
    logic       mem_rd;
    logic [6:0] mem_rdata;
    logic [6:0] blk_map;
    logic [6:0] blk_now;
    logic       blk_do;
    logic [6:0] blk_start;
    logic [6:0] blk_goal;
    logic [6:0] start_pos;
    logic [6:0] goal_pos;
    logic       start_found;
    logic       goal_found;
    logic       err_dup;
    logic       err_missing;
    logic [6:0] wall_cnt;

    map_scan_ctrl #(
        .CELLS (4),
        .ADDR_W(7),
        .DATA_W(7),
        .RD_LAT(1)
    ) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .scan_req   (scan_req),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .blk_map    (blk_map),
        .blk_now    (blk_now),
        .blk_do     (blk_do),
        .blk_start  (blk_start),
        .blk_goal   (blk_goal),
        .start_pos  (start_pos),
        .goal_pos   (goal_pos),
        .start_found(start_found),
        .goal_found (goal_found),
        .err_dup    (err_dup),
        .err_missing(err_missing),
        .wall_cnt   (wall_cnt)
    );

`ifdef MAP_SCAN_WALL_CNT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // Map RAM model, one cycle read latency
    logic [6:0] ram [4];
    always_ff @(posedge m_clock) begin
        if (mem_rd) mem_rdata <= ram[mem_addr[1:0]];
    end

    // Search stage model: echoes the current index, junk otherwise
    assign blk_start = blk_do ? blk_now : 7'h7F;
    assign blk_goal  = blk_do ? blk_now : 7'h7F;

    typedef struct packed {
        logic [6:0] idx;
        logic [6:0] code;
    } feed_t;

    typedef struct packed {
        logic [0:3][6:0] ram;
        logic [6:0]      sp;
        logic [6:0]      gp;
        logic            sf;
        logic            gf;
        logic            dup;
        logic            miss;
        logic [6:0]      wall;
    } vec_t;

    feed_t q[$];
    int    n_total;
    int    n_pass;
    int    done_cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge m_clock) begin
        if (p_reset && scan_done) done_cnt++;
        if (p_reset && blk_do) begin
            if (q.size() == 0) begin
                chk("unexpected_blk_do", {57'd0, blk_now}, 64'h7F);
            end else begin
                feed_t e;
                e = q.pop_front();
                chk("blk_now", {57'd0, blk_now}, {57'd0, e.idx});
                chk("blk_map", {57'd0, blk_map}, {57'd0, e.code});
            end
        end
    end

    task automatic push_scan(input logic [0:3][6:0] r);
        for (int i = 0; i < 4; i++) begin
            ram[i] = r[i];
            q.push_back('{idx: 7'(i), code: r[i]});
        end
    endtask

    task automatic wait_done(input int budget, input bit drop,
                             output int cyc);
        cyc = 0;
        do begin
            @(negedge m_clock);
            cyc++;
            if (drop) scan_req = 1'b0;
        end while (!scan_done && cyc < budget);
        if (!scan_done) cyc = -1;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        push_scan(v.ram);
        @(negedge m_clock);
        scan_req = 1'b1;
        wait_done(40, 1'b1, cyc);
        chk("done_latency", 64'(cyc), 64'd13);
        chk("start_pos", {57'd0, start_pos}, {57'd0, v.sp});
        chk("goal_pos", {57'd0, goal_pos}, {57'd0, v.gp});
        chk("start_found", {63'd0, start_found}, {63'd0, v.sf});
        chk("goal_found", {63'd0, goal_found}, {63'd0, v.gf});
        chk("err_dup", {63'd0, err_dup}, {63'd0, v.dup});
        chk("err_missing", {63'd0, err_missing}, {63'd0, v.miss});
        chk("wall_cnt", {57'd0, wall_cnt},
            WEN ? {57'd0, v.wall} : 64'd0);
        chk("feeds_left", 64'(q.size()), 64'd0);
        @(negedge m_clock);
    endtask

    function automatic logic [63:0] all_out();
        return {14'd0, scan_busy, scan_done, mem_addr, mem_rd, blk_map,
                blk_now, blk_do, start_pos, goal_pos, start_found,
                goal_found, err_dup, err_missing, wall_cnt};
    endfunction

    vec_t tv [4];

    initial begin
        int cyc;
        int d0;
        bit hit;
        n_total  = 0;
        n_pass   = 0;
        done_cnt = 0;
        // ram, sp, gp, sf, gf, dup, miss, wall
        tv[0] = '{'{7'h40, 7'h3F, 7'h20, 7'h00},
                  7'd1, 7'd3, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1};
        tv[1] = '{'{7'h3F, 7'h3F, 7'h00, 7'h40},
                  7'd0, 7'd2, 1'b1, 1'b1, 1'b1, 1'b0, 7'd1};
        tv[2] = '{'{7'h40, 7'h40, 7'h20, 7'h3F},
                  7'd3, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd2};
        tv[3] = '{'{7'h40, 7'h41, 7'h3F, 7'h00},
                  7'd2, 7'd3, 1'b1, 1'b1, 1'b0, 1'b0, 7'd2};

        p_reset  = 1'b0;
        scan_req = 1'b0;
        repeat (2) @(negedge m_clock);
        chk("reset_outputs", all_out(), 64'd0);
        p_reset = 1'b1;
        @(negedge m_clock);
        chk("idle_outputs", all_out(), 64'd0);

        for (int i = 0; i < 4; i++) run_vec(tv[i]);

        // Asynchronous reset while cell 2 is being fed
        push_scan(tv[0].ram);
        @(negedge m_clock);
        scan_req = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge m_clock);
            scan_req = 1'b0;
            #1;
            if (blk_do && blk_now == 7'd2) hit = 1'b1;
        end
        chk("reach_idx2_feed", {63'd0, hit}, 64'd1);
        chk("busy_mid_scan", {63'd0, scan_busy}, 64'd1);
        d0 = done_cnt;
        p_reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 64'd0);
        q.delete();
        repeat (3) @(negedge m_clock);
        p_reset = 1'b1;
        repeat (4) @(negedge m_clock);
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
        chk("idle_after_reset", all_out(), 64'd0);
        run_vec(tv[0]);

        // scan_req held high: two back-to-back scans
        push_scan(tv[1].ram);
        push_scan(tv[1].ram);
        d0 = done_cnt;
        @(negedge m_clock);
        scan_req = 1'b1;
        wait_done(40, 1'b0, cyc);
        chk("b2b_first_done", 64'(cyc), 64'd13);
        chk("b2b_first_dup", {63'd0, err_dup}, 64'd1);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge m_clock);
            if (scan_busy) hit = 1'b1;
        end
        chk("b2b_restart", {63'd0, hit}, 64'd1);
        chk("b2b_cleared", {61'd0, start_found, goal_found, err_dup},
            64'd0);
        scan_req = 1'b0;
        wait_done(40, 1'b0, cyc);
        chk("b2b_second_done", 64'(cyc), 64'd12);
        chk("b2b_second_dup", {63'd0, err_dup}, 64'd1);
        repeat (20) @(negedge m_clock);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        chk("b2b_feeds_left", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
